// File: rtl/huc6261_pkg.sv
// Shared constants and state encoding for the HuC6261 colour-palette loader.
// AR values select which 6261 register the following data-port write targets.
package huc6261_pkg;

    localparam logic [4:0] AR_CPA    = 5'd1;
    localparam logic [4:0] AR_CPD    = 5'd2;
    localparam logic [4:0] AR_CPD_RD = 5'd3;
    localparam logic [4:0] AR_CPAO   = 5'd4;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        WAIT    = 4'd1,
        SEL_CPA = 4'd2,
        WR_CPA  = 4'd3,
        SEL_CPD = 4'd4,
        WR_DATA = 4'd5,
        GAP     = 4'd6,
        RESTORE = 4'd7,
        DONE    = 4'd8
    } cp_ld_state_t;

    function automatic logic is_stroke(input cp_ld_state_t s);
        return (s == SEL_CPA) || (s == WR_CPA) || (s == SEL_CPD) ||
               (s == WR_DATA) || (s == RESTORE);
    endfunction

endpackage

// File: rtl/huc6261_cp_loader.sv
// Shares the HuC6261 register port between the CPU and a streaming palette loader.
// The loader owns the port only during single-cycle write strokes; the CPU owns it otherwise.
module huc6261_cp_loader
    import huc6261_pkg::*;
#(
    parameter int GAP_CE = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic        CPU_CSn,
    input  logic        CPU_WRn,
    input  logic        CPU_RDn,
    input  logic        CPU_A2,
    input  logic [15:0] CPU_DI,
    output logic [15:0] CPU_DO,
    output logic        CPU_READY,
    input  logic        LD_START,
    input  logic [8:0]  LD_ADDR,
    input  logic [9:0]  LD_COUNT,
    input  logic [15:0] LD_DATA,
    input  logic        LD_VALID,
    output logic        LD_READY,
    output logic        LD_BUSY,
    output logic        LD_DONE,
    output logic        CSn,
    output logic        WRn,
    output logic        RDn,
    output logic        A2,
    output logic [15:0] DO,
    input  logic [15:0] DI
);

    localparam int GW = (GAP_CE > 1) ? $clog2(GAP_CE) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CE - 1);

    cp_ld_state_t state;
    cp_ld_state_t ret_state;
    cp_ld_state_t pick;
    cp_ld_state_t gap_exit;
    logic [GW-1:0] gap_cnt;
    logic [8:0]    cur_addr;
    logic [9:0]    remain;
    logic [4:0]    ar_shadow;
    logic          cpu_touched;
    logic          need_cpa;
    logic          ld_own;
    logic          cpu_wr;
    logic          busy;

    assign ld_own = is_stroke(state);
    assign cpu_wr = ~ld_own & ~CPU_CSn & ~CPU_WRn;
    assign busy   = (state != IDLE) && (state != DONE);

    // Next stroke once the port is free: a CPU write may have moved AR/CPA, so reselect fully.
    always_comb begin
        pick = WAIT;
        if (CPU_CSn) begin
            if (need_cpa || cpu_touched)
                pick = SEL_CPA;
            else if (LD_VALID)
                pick = WR_DATA;
        end
    end

    always_comb begin
        gap_exit = ret_state;
        case (ret_state)
            WAIT: gap_exit = pick;
            WR_CPA, SEL_CPD: begin
                if (!CPU_CSn)
                    gap_exit = GAP;
                else if (cpu_touched)
                    gap_exit = SEL_CPA;
            end
            RESTORE: if (!CPU_CSn) gap_exit = GAP;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            ret_state   <= IDLE;
            gap_cnt     <= '0;
            cur_addr    <= '0;
            remain      <= '0;
            ar_shadow   <= '0;
            cpu_touched <= 1'b0;
            need_cpa    <= 1'b0;
        end else if (CE) begin
            if (cpu_wr && !CPU_A2)
                ar_shadow <= CPU_DI[4:0];
            if (cpu_wr && busy)
                cpu_touched <= 1'b1;
            case (state)
                IDLE: begin
                    if (LD_START) begin
                        cur_addr    <= LD_ADDR;
                        remain      <= LD_COUNT;
                        need_cpa    <= 1'b1;
                        cpu_touched <= 1'b0;
                        state       <= (LD_COUNT == 10'd0) ? DONE : WAIT;
                    end
                end
                WAIT: state <= pick;
                SEL_CPA: begin
                    cpu_touched <= 1'b0;
                    need_cpa    <= 1'b0;
                    ret_state   <= WR_CPA;
                    gap_cnt     <= GAP_LOAD;
                    state       <= GAP;
                end
                WR_CPA: begin
                    ret_state <= SEL_CPD;
                    gap_cnt   <= GAP_LOAD;
                    state     <= GAP;
                end
                SEL_CPD: begin
                    ret_state <= WAIT;
                    gap_cnt   <= GAP_LOAD;
                    state     <= GAP;
                end
                WR_DATA: begin
                    cur_addr  <= cur_addr + 9'd1;
                    remain    <= remain - 10'd1;
                    ret_state <= (remain == 10'd1) ? RESTORE : WAIT;
                    gap_cnt   <= GAP_LOAD;
                    state     <= GAP;
                end
                GAP: begin
                    if (gap_cnt != '0)
                        gap_cnt <= gap_cnt - 1'b1;
                    else
                        state <= gap_exit;
                end
                RESTORE: begin
                    ret_state <= DONE;
                    gap_cnt   <= GAP_LOAD;
                    state     <= GAP;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        CSn       = CPU_CSn;
        WRn       = CPU_WRn;
        RDn       = CPU_RDn;
        A2        = CPU_A2;
        DO        = CPU_DI;
        CPU_READY = 1'b1;
        if (ld_own) begin
            CSn       = 1'b0;
            WRn       = 1'b0;
            RDn       = 1'b1;
            CPU_READY = CPU_CSn;
            case (state)
                SEL_CPA: begin A2 = 1'b0; DO = {11'b0, AR_CPA};    end
                WR_CPA:  begin A2 = 1'b1; DO = {7'b0, cur_addr};   end
                SEL_CPD: begin A2 = 1'b0; DO = {11'b0, AR_CPD};    end
                WR_DATA: begin A2 = 1'b1; DO = LD_DATA;            end
                default: begin A2 = 1'b0; DO = {11'b0, ar_shadow}; end
            endcase
        end
        // Strobes must release the instant reset asserts, even mid-stroke.
        if (RST) begin
            CSn       = 1'b1;
            WRn       = 1'b1;
            RDn       = 1'b1;
            A2        = 1'b0;
            DO        = '0;
            CPU_READY = 1'b1;
        end
    end

    assign CPU_DO   = DI;
    assign LD_READY = CE & LD_VALID & (state == WR_DATA);
    assign LD_BUSY  = busy;
    assign LD_DONE  = CE & (state == DONE);

endmodule

// File: tb/tb_huc6261_cp_loader.sv
// Directed bench: a behavioural 6261 write-port model records every stroke and palette write.
module tb_huc6261_cp_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CE = 1'b1;
    logic        CPU_CSn = 1'b1;
    logic        CPU_WRn = 1'b1;
    logic        CPU_RDn = 1'b0;
    logic        CPU_A2 = 1'b1;
    logic [15:0] CPU_DI = 16'hFFFF;
    logic [15:0] CPU_DO;
    logic        CPU_READY;
    logic        LD_START = 1'b0;
    logic [8:0]  LD_ADDR = '0;
    logic [9:0]  LD_COUNT = '0;
    logic [15:0] LD_DATA;
    logic        LD_VALID;
    logic        LD_READY;
    logic        LD_BUSY;
    logic        LD_DONE;
    logic        CSn, WRn, RDn, A2;
    logic [15:0] DO;
    logic [15:0] DI = 16'h0000;

    always #5 CLK = ~CLK;

    huc6261_cp_loader #(.GAP_CE(2)) dut (
        .CLK(CLK), .RST(RST), .CE(CE),
        .CPU_CSn(CPU_CSn), .CPU_WRn(CPU_WRn), .CPU_RDn(CPU_RDn), .CPU_A2(CPU_A2),
        .CPU_DI(CPU_DI), .CPU_DO(CPU_DO), .CPU_READY(CPU_READY),
        .LD_START(LD_START), .LD_ADDR(LD_ADDR), .LD_COUNT(LD_COUNT),
        .LD_DATA(LD_DATA), .LD_VALID(LD_VALID), .LD_READY(LD_READY),
        .LD_BUSY(LD_BUSY), .LD_DONE(LD_DONE),
        .CSn(CSn), .WRn(WRn), .RDn(RDn), .A2(A2), .DO(DO), .DI(DI)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [16:0] log_q[$];
    int          log_cyc[$];
    logic [16:0] exp_q[$];
    logic [15:0] pal [0:511];
    logic [4:0]  m_ar = 5'd0;
    logic [8:0]  m_cpa = 9'd0;

    logic [15:0] src [0:31];
    int          src_idx = 0;
    int          src_len = 0;

    assign LD_DATA  = src[src_idx[4:0]];
    assign LD_VALID = (src_idx < src_len);

    always @(posedge CLK) cyc <= cyc + 1;
    always @(posedge CLK) if (LD_READY) src_idx <= src_idx + 1;

    // 6261 write-port model: AR selects CPA (auto-incrementing 9-bit) or CPD.
    always @(negedge CLK) begin
        if (!RST && !CSn && !WRn) begin
            log_q.push_back({A2, DO});
            log_cyc.push_back(cyc);
            if (!A2)
                m_ar = DO[4:0];
            else if (m_ar == 5'd1)
                m_cpa = DO[8:0];
            else if (m_ar == 5'd2) begin
                pal[m_cpa] = DO;
                m_cpa = m_cpa + 9'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ex(input logic a2, input logic [15:0] d);
        exp_q.push_back({a2, d});
    endtask

    task automatic clear_log();
        log_q.delete();
        log_cyc.delete();
        exp_q.delete();
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_nstrokes"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk($sformatf("%s_stroke%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    endtask

    task automatic cpu_write(input logic a2, input logic [15:0] d);
        logic got;
        got = 1'b0;
        CPU_CSn = 1'b0; CPU_WRn = 1'b0; CPU_A2 = a2; CPU_DI = d;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge CLK);
            got = CPU_READY;
        end
        if (!got) chk("cpu_write_ready", 32'(got), 32'd1);
        tick();
        CPU_CSn = 1'b1; CPU_WRn = 1'b1; CPU_A2 = 1'b0; CPU_DI = 16'h0000;
    endtask

    task automatic start_load(input logic [8:0] addr, input logic [9:0] count);
        LD_ADDR = addr; LD_COUNT = count; LD_START = 1'b1;
        tick();
        LD_START = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!LD_DONE && k < 300) begin tick(); k++; end
        chk({tag, "_done_seen"}, 32'(LD_DONE), 32'd1);
        tick();
        chk({tag, "_done_pulse"}, 32'(LD_DONE), 32'd0);
        chk({tag, "_busy_after"}, 32'(LD_BUSY), 32'd0);
    endtask

    task automatic wait_src(input string tag, input int n);
        int k;
        k = 0;
        while (src_idx != n && k < 200) begin tick(); k++; end
        chk({tag, "_consumed"}, 32'(src_idx), 32'(n));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < 32; i++) src[i] = 16'h0000;
        for (int i = 0; i < 512; i++) pal[i] = 16'h0000;

        // Reset: pins forced idle even though the CPU inputs are active.
        repeat (3) tick();
        chk("rst_CSn", 32'(CSn), 32'd1);
        chk("rst_WRn", 32'(WRn), 32'd1);
        chk("rst_RDn", 32'(RDn), 32'd1);
        chk("rst_A2", 32'(A2), 32'd0);
        chk("rst_DO", 32'(DO), 32'd0);
        chk("rst_ready", 32'(CPU_READY), 32'd1);
        chk("rst_ld_flags", {29'b0, LD_READY, LD_BUSY, LD_DONE}, 32'd0);
        CPU_RDn = 1'b1; CPU_A2 = 1'b0; CPU_DI = 16'h0000;
        RST = 1'b0;
        tick();

        // Basic load of three entries at 0x010.
        cpu_write(1'b0, 16'h0005);
        clear_log();
        src[0] = 16'hA111; src[1] = 16'hB222; src[2] = 16'hC333; src_len = 3;
        start_load(9'h010, 10'd3);
        chk("t1_busy", 32'(LD_BUSY), 32'd1);
        wait_done("t1");
        ex(0, 16'h0001); ex(1, 16'h0010); ex(0, 16'h0002);
        ex(1, 16'hA111); ex(1, 16'hB222); ex(1, 16'hC333); ex(0, 16'h0005);
        chk_log("t1");
        for (int i = 1; i < log_cyc.size(); i++)
            chk($sformatf("t1_spacing%0d", i), 32'(log_cyc[i] - log_cyc[i-1]), 32'd3);
        chk("t1_pal10", 32'(pal[9'h010]), 32'hA111);
        chk("t1_pal11", 32'(pal[9'h011]), 32'hB222);
        chk("t1_pal12", 32'(pal[9'h012]), 32'hC333);

        // Wrap 0x1FF -> 0x000; restore of CPU-selected AR=4.
        cpu_write(1'b0, 16'h0004);
        clear_log();
        src[3] = 16'hD001; src[4] = 16'hD002; src_len = 5;
        start_load(9'h1FF, 10'd2);
        wait_done("t2");
        ex(0, 16'h0001); ex(1, 16'h01FF); ex(0, 16'h0002);
        ex(1, 16'hD001); ex(1, 16'hD002); ex(0, 16'h0004);
        chk_log("t2");
        chk("t2_pal1ff", 32'(pal[9'h1FF]), 32'hD001);
        chk("t2_pal000", 32'(pal[9'h000]), 32'hD002);

        // CPU writes AR=3 between data strokes: full reselect before next data.
        clear_log();
        src[5] = 16'hE001; src_len = 6;
        start_load(9'h020, 10'd2);
        wait_src("t3", 6);
        cpu_write(1'b0, 16'h0003);
        repeat (12) tick();
        src[6] = 16'hE002; src_len = 7;
        wait_done("t3");
        ex(0, 16'h0001); ex(1, 16'h0020); ex(0, 16'h0002); ex(1, 16'hE001);
        ex(0, 16'h0003);
        ex(0, 16'h0001); ex(1, 16'h0021); ex(0, 16'h0002); ex(1, 16'hE002);
        ex(0, 16'h0003);
        chk_log("t3");
        chk("t3_pal20", 32'(pal[9'h020]), 32'hE001);
        chk("t3_pal21", 32'(pal[9'h021]), 32'hE002);

        // CPU selects during the data stroke: stalled, then completes in the gap.
        clear_log();
        src[7] = 16'hF001; src_len = 8;
        start_load(9'h030, 10'd1);
        k = 0;
        while (!LD_READY && k < 100) begin tick(); k++; end
        chk("t4_in_data_stroke", 32'(LD_READY), 32'd1);
        CPU_CSn = 1'b0; CPU_WRn = 1'b0; CPU_A2 = 1'b0; CPU_DI = 16'h0006;
        #1;
        chk("t4_stall_ready", 32'(CPU_READY), 32'd0);
        chk("t4_stall_pins", {15'b0, CSn, WRn, A2, DO}, {15'b0, 1'b0, 1'b0, 1'b1, 16'hF001});
        tick();
        chk("t4_gap_ready", 32'(CPU_READY), 32'd1);
        chk("t4_gap_pins", {15'b0, CSn, WRn, A2, DO}, {15'b0, 1'b0, 1'b0, 1'b0, 16'h0006});
        tick();
        CPU_CSn = 1'b1; CPU_WRn = 1'b1; CPU_DI = 16'h0000;
        wait_done("t4");
        ex(0, 16'h0001); ex(1, 16'h0030); ex(0, 16'h0002); ex(1, 16'hF001);
        ex(0, 16'h0006); ex(0, 16'h0006);
        chk_log("t4");
        chk("t4_pal30", 32'(pal[9'h030]), 32'hF001);

        // LD_VALID low for 20 cycles: port follows CPU, LD_START ignored, then resume.
        clear_log();
        src[8] = 16'h5A01; src_len = 9;
        start_load(9'h040, 10'd3);
        wait_src("t5", 9);
        repeat (5) tick();
        CPU_CSn = 1'b0; CPU_RDn = 1'b0; CPU_A2 = 1'b1; DI = 16'hBEEF;
        #1;
        chk("t5_cpu_rd_pins", {29'b0, CSn, RDn, A2}, {29'b0, 1'b0, 1'b0, 1'b1});
        chk("t5_cpu_rd_data", 32'(CPU_DO), 32'hBEEF);
        chk("t5_cpu_rd_ready", 32'(CPU_READY), 32'd1);
        tick();
        CPU_CSn = 1'b1; CPU_RDn = 1'b1; CPU_A2 = 1'b0;
        start_load(9'h100, 10'd5);
        repeat (13) tick();
        chk("t5_stalled_strokes", 32'(log_q.size()), 32'd4);
        chk("t5_stalled_busy", 32'(LD_BUSY), 32'd1);
        src[9] = 16'h5A02; src[10] = 16'h5A03; src_len = 11;
        wait_done("t5");
        ex(0, 16'h0001); ex(1, 16'h0040); ex(0, 16'h0002);
        ex(1, 16'h5A01); ex(1, 16'h5A02); ex(1, 16'h5A03); ex(0, 16'h0006);
        chk_log("t5");
        chk("t5_pal42", 32'(pal[9'h042]), 32'h5A03);

        // Zero-length load.
        clear_log();
        start_load(9'h000, 10'd0);
        chk("t6_done", 32'(LD_DONE), 32'd1);
        chk("t6_busy", 32'(LD_BUSY), 32'd0);
        tick();
        chk("t6_done_pulse", 32'(LD_DONE), 32'd0);
        chk("t6_nstrokes", 32'(log_q.size()), 32'd0);

        // Reset mid-stroke releases the strobes immediately.
        start_load(9'h050, 10'd1);
        k = 0;
        while (CSn && k < 20) begin tick(); k++; end
        chk("t7_in_stroke", {30'b0, CSn, WRn}, 32'd0);
        RST = 1'b1;
        #1;
        chk("t7_rst_strobes", {30'b0, CSn, WRn}, 32'd3);
        chk("t7_rst_busy", 32'(LD_BUSY), 32'd0);
        tick();
        RST = 1'b0;
        tick();
        chk("t7_post_idle", {30'b0, LD_BUSY, CPU_READY}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
